// File: rtl/hex_display_pkg.sv
// Shared character codes, message selectors and sequencer states for the
// six-digit HEX display path.
package hex_display_pkg;

  typedef logic [8:0] char_code_t;

  localparam char_code_t CODE_BLANK = 9'd20;
  localparam char_code_t CODE_DASH  = 9'd30;

  // START occupies 21..25, DONE 26..29, MOLE 33..36
  localparam char_code_t CODE_S  = 9'd21;
  localparam char_code_t CODE_T1 = 9'd22;
  localparam char_code_t CODE_A  = 9'd23;
  localparam char_code_t CODE_R  = 9'd24;
  localparam char_code_t CODE_T  = 9'd25;
  localparam char_code_t CODE_D  = 9'd26;
  localparam char_code_t CODE_O  = 9'd27;
  localparam char_code_t CODE_N  = 9'd28;
  localparam char_code_t CODE_E  = 9'd29;
  localparam char_code_t CODE_M  = 9'd33;
  localparam char_code_t CODE_O2 = 9'd34;
  localparam char_code_t CODE_L  = 9'd35;
  localparam char_code_t CODE_E2 = 9'd36;

  typedef enum logic [1:0] {MSG_START, MSG_DONE, MSG_MOLE, MSG_RSVD} msg_sel_t;

  typedef enum logic [1:0] {ST_SCORE, ST_SHIFT_IN, ST_HOLD, ST_SHIFT_OUT} seq_state_t;

endpackage

// File: rtl/hex_tick_gen.sv
// Step-rate divider: pulses o_tick for one cycle every TICK_CYCLES clocks,
// restarting from zero whenever i_clear is high.
module hex_tick_gen #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == CNT_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/hex_message_sequencer.sv
// Drives the six HEX character codes: score in idle, otherwise a scrolling
// START / DONE / MOLE message that shifts in, holds, and shifts out.
module hex_message_sequencer
  import hex_display_pkg::*;
#(
  parameter int TICK_CYCLES = 50_000_000,
  parameter int HOLD_TICKS  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  Score,
  input  logic        MsgReq,
  input  logic [1:0]  MsgSel,
  output logic        MsgAck,
  output logic        Busy,
  output logic [53:0] DigitCodes
);

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  seq_state_t      r_state, w_stateNext;
  msg_sel_t        r_msg, w_msgNext;
  logic [2:0]      r_idx, w_idxNext;
  logic [HW-1:0]   r_holdCnt, w_holdCntNext;
  logic [53:0]     r_disp, w_dispNext;
  logic            r_ack, w_ackNext;
  logic            r_busy;
  logic            w_tick;
  logic            w_accept;
  char_code_t      w_msgChar;
  logic [2:0]      w_msgLast;
  logic [6:0]      w_tensBin, w_onesBin;
  char_code_t      w_hex1, w_hex0;

  assign w_accept = (r_state == ST_SCORE) && MsgReq && (MsgSel != 2'(MSG_RSVD));

  hex_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_accept),
    .o_tick  (w_tick)
  );

  // Message ROM: each message is a contiguous run of codes from its first letter
  always_comb begin
    w_msgChar = CODE_BLANK;
    w_msgLast = 3'd3;
    case (r_msg)
      MSG_START: begin
        w_msgChar = CODE_S + char_code_t'(r_idx);
        w_msgLast = 3'd4;
      end
      MSG_DONE:  w_msgChar = CODE_D + char_code_t'(r_idx);
      MSG_MOLE:  w_msgChar = CODE_M + char_code_t'(r_idx);
      default:   w_msgChar = CODE_BLANK;
    endcase
  end

  always_comb begin
    w_tensBin = Score / 7'd10;
    w_onesBin = Score % 7'd10;
    if (Score > 7'd99) begin
      w_hex1 = CODE_DASH;
      w_hex0 = CODE_DASH;
    end else begin
      w_hex1 = (w_tensBin == 7'd0) ? CODE_BLANK : {2'b00, w_tensBin};
      w_hex0 = {2'b00, w_onesBin};
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_msgNext     = r_msg;
    w_idxNext     = r_idx;
    w_holdCntNext = r_holdCnt;
    w_dispNext    = r_disp;
    w_ackNext     = 1'b0;
    case (r_state)
      ST_SCORE: begin
        w_dispNext = {{4{CODE_BLANK}}, w_hex1, w_hex0};
        w_ackNext  = MsgReq;
        if (w_accept) begin
          w_stateNext = ST_SHIFT_IN;
          w_msgNext   = msg_sel_t'(MsgSel);
          w_idxNext   = 3'd0;
          w_dispNext  = {6{CODE_BLANK}};
        end
      end
      ST_SHIFT_IN: begin
        if (w_tick) begin
          w_dispNext = {r_disp[44:0], w_msgChar};
          w_idxNext  = r_idx + 3'd1;
          if (r_idx == w_msgLast) begin
            w_stateNext   = ST_HOLD;
            w_holdCntNext = '0;
          end
        end
      end
      ST_HOLD: begin
        if (w_tick) begin
          w_holdCntNext = r_holdCnt + HW'(1);
          if (r_holdCnt == HOLD_LAST) begin
            w_stateNext = ST_SHIFT_OUT;
            w_idxNext   = 3'd0;
          end
        end
      end
      ST_SHIFT_OUT: begin
        if (w_tick) begin
          w_dispNext = {r_disp[44:0], CODE_BLANK};
          w_idxNext  = r_idx + 3'd1;
          if (r_idx == 3'd5) begin
            w_stateNext = ST_SCORE;
          end
        end
      end
      default: w_stateNext = ST_SCORE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_SCORE;
      r_msg     <= MSG_START;
      r_idx     <= 3'd0;
      r_holdCnt <= '0;
      r_disp    <= {6{CODE_BLANK}};
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_msg     <= w_msgNext;
      r_idx     <= w_idxNext;
      r_holdCnt <= w_holdCntNext;
      r_disp    <= w_dispNext;
      r_ack     <= w_ackNext;
      r_busy    <= (w_stateNext != ST_SCORE);
    end
  end

  assign MsgAck     = r_ack;
  assign Busy       = r_busy;
  assign DigitCodes = r_disp;

endmodule

// File: tb/tb_hex_message_sequencer.sv
// Directed bench for hex_message_sequencer with a fast tick (4 cycles) and
// two hold steps; expected codes are written out by hand per step.
module tb_hex_message_sequencer;

  localparam int TICK_CYCLES = 4;
  localparam int HOLD_TICKS  = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  Score = 7'd0;
  logic        MsgReq = 1'b0;
  logic [1:0]  MsgSel = 2'd0;
  logic        MsgAck;
  logic        Busy;
  logic [53:0] DigitCodes;

  int checkCount = 0;
  int errorCount = 0;

  hex_message_sequencer #(
    .TICK_CYCLES(TICK_CYCLES),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Score      (Score),
    .MsgReq     (MsgReq),
    .MsgSel     (MsgSel),
    .MsgAck     (MsgAck),
    .Busy       (Busy),
    .DigitCodes (DigitCodes)
  );

  always #5 clk = ~clk;

  function automatic logic [53:0] pack6(input int h5, input int h4, input int h3,
                                        input int h2, input int h1, input int h0);
    return {9'(h5), 9'(h4), 9'(h3), 9'(h2), 9'(h1), 9'(h0)};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [1:0] sel, input logic [6:0] score);
    MsgReq = req;
    MsgSel = sel;
    Score  = score;
  endtask

  task automatic stepClocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // reset and score display
    applyStimulus(1'b0, 2'd0, 7'd47);
    stepClocks(1);
    checkOutput("rst_disp", 64'(DigitCodes), 64'(pack6(20, 20, 20, 20, 20, 20)));
    checkOutput("rst_busy", 64'(Busy), 64'd0);
    checkOutput("rst_ack", 64'(MsgAck), 64'd0);
    reset_n = 1'b1;
    stepClocks(1);
    checkOutput("score47", 64'(DigitCodes), 64'(pack6(20, 20, 20, 20, 4, 7)));
    checkOutput("score47_busy", 64'(Busy), 64'd0);
    applyStimulus(1'b0, 2'd0, 7'd7);
    stepClocks(1);
    checkOutput("score7", 64'(DigitCodes), 64'(pack6(20, 20, 20, 20, 20, 7)));
    applyStimulus(1'b0, 2'd0, 7'd120);
    stepClocks(1);
    checkOutput("score120", 64'(DigitCodes), 64'(pack6(20, 20, 20, 20, 30, 30)));
    applyStimulus(1'b0, 2'd0, 7'd0);
    stepClocks(1);
    checkOutput("score0", 64'(DigitCodes), 64'(pack6(20, 20, 20, 20, 20, 0)));
    applyStimulus(1'b0, 2'd0, 7'd99);
    stepClocks(1);
    checkOutput("score99", 64'(DigitCodes), 64'(pack6(20, 20, 20, 20, 9, 9)));
    applyStimulus(1'b0, 2'd0, 7'd100);
    stepClocks(1);
    checkOutput("score100", 64'(DigitCodes), 64'(pack6(20, 20, 20, 20, 30, 30)));

    // reserved selector: ack only
    applyStimulus(1'b1, 2'd3, 7'd99);
    stepClocks(1);
    checkOutput("rsvd_ack", 64'(MsgAck), 64'd1);
    checkOutput("rsvd_busy", 64'(Busy), 64'd0);
    checkOutput("rsvd_disp", 64'(DigitCodes), 64'(pack6(20, 20, 20, 20, 9, 9)));
    applyStimulus(1'b0, 2'd0, 7'd47);
    stepClocks(1);
    checkOutput("rsvd_ack_end", 64'(MsgAck), 64'd0);
    checkOutput("rsvd_disp2", 64'(DigitCodes), 64'(pack6(20, 20, 20, 20, 4, 7)));

    // START message
    applyStimulus(1'b1, 2'd0, 7'd47);
    stepClocks(1);
    checkOutput("start_ack", 64'(MsgAck), 64'd1);
    checkOutput("start_busy", 64'(Busy), 64'd1);
    checkOutput("start_clear", 64'(DigitCodes), 64'(pack6(20, 20, 20, 20, 20, 20)));
    applyStimulus(1'b0, 2'd0, 7'd47);
    stepClocks(1);
    checkOutput("start_ack_pulse", 64'(MsgAck), 64'd0);
    stepClocks(2);
    checkOutput("start_pretick", 64'(DigitCodes), 64'(pack6(20, 20, 20, 20, 20, 20)));
    stepClocks(1);
    checkOutput("start_tick1", 64'(DigitCodes), 64'(pack6(20, 20, 20, 20, 20, 21)));
    applyStimulus(1'b0, 2'd0, 7'd63);
    stepClocks(16);
    checkOutput("start_full", 64'(DigitCodes), 64'(pack6(20, 21, 22, 23, 24, 25)));
    stepClocks(31);
    checkOutput("start_busy51", 64'(Busy), 64'd1);
    checkOutput("start_out5", 64'(DigitCodes), 64'(pack6(25, 20, 20, 20, 20, 20)));
    stepClocks(1);
    checkOutput("start_busy52", 64'(Busy), 64'd0);
    checkOutput("start_blank52", 64'(DigitCodes), 64'(pack6(20, 20, 20, 20, 20, 20)));
    stepClocks(1);
    checkOutput("start_score", 64'(DigitCodes), 64'(pack6(20, 20, 20, 20, 6, 3)));

    // MOLE message with a request during HOLD and a held request at completion
    applyStimulus(1'b1, 2'd2, 7'd63);
    stepClocks(1);
    checkOutput("mole_ack", 64'(MsgAck), 64'd1);
    applyStimulus(1'b0, 2'd0, 7'd63);
    stepClocks(16);
    checkOutput("mole_full", 64'(DigitCodes), 64'(pack6(20, 20, 33, 34, 35, 36)));
    checkOutput("mole_busy", 64'(Busy), 64'd1);
    stepClocks(1);
    applyStimulus(1'b1, 2'd1, 7'd63);
    stepClocks(1);
    checkOutput("hold_noack", 64'(MsgAck), 64'd0);
    checkOutput("hold_disp", 64'(DigitCodes), 64'(pack6(20, 20, 33, 34, 35, 36)));
    applyStimulus(1'b0, 2'd0, 7'd63);
    stepClocks(29);
    checkOutput("mole_busy47", 64'(Busy), 64'd1);
    checkOutput("mole_out5", 64'(DigitCodes), 64'(pack6(36, 20, 20, 20, 20, 20)));
    applyStimulus(1'b1, 2'd0, 7'd63);
    stepClocks(1);
    checkOutput("mole_busy48", 64'(Busy), 64'd0);
    checkOutput("fall_noack", 64'(MsgAck), 64'd0);
    checkOutput("mole_blank48", 64'(DigitCodes), 64'(pack6(20, 20, 20, 20, 20, 20)));
    stepClocks(1);
    checkOutput("reaccept_ack", 64'(MsgAck), 64'd1);
    checkOutput("reaccept_busy", 64'(Busy), 64'd1);
    checkOutput("reaccept_disp", 64'(DigitCodes), 64'(pack6(20, 20, 20, 20, 20, 20)));
    applyStimulus(1'b0, 2'd0, 7'd63);
    stepClocks(4);
    checkOutput("reaccept_tick1", 64'(DigitCodes), 64'(pack6(20, 20, 20, 20, 20, 21)));

    // asynchronous reset during SHIFT_IN
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_disp", 64'(DigitCodes), 64'(pack6(20, 20, 20, 20, 20, 20)));
    checkOutput("arst_busy", 64'(Busy), 64'd0);
    checkOutput("arst_ack", 64'(MsgAck), 64'd0);
    stepClocks(2);
    reset_n = 1'b1;
    stepClocks(1);
    checkOutput("arst_score", 64'(DigitCodes), 64'(pack6(20, 20, 20, 20, 6, 3)));
    checkOutput("arst_busy_after", 64'(Busy), 64'd0);
    stepClocks(5);
    checkOutput("arst_no_shift", 64'(DigitCodes), 64'(pack6(20, 20, 20, 20, 6, 3)));

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
